// File: rtl/ysyx_23060077_lsu.sv
// Load/store unit sitting directly behind the execute stage.
// Issues one valid/ready memory request per load or store, aligns store data
// and byte strobes to the addressed lanes, extracts and extends load data, and
// holds a registered result plus finished/fault flags until writeback takes it.
// Non-memory instructions bypass the memory port and finish one cycle later.

module ysyx_23060077_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LSB   = 2
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic                      ex_to_ls,
    input  logic                      mem_ren,
    input  logic                      mem_wen,
    input  logic [2:0]                funct3,
    input  logic [DATA_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH-1:0]     exu_result,
    input  logic                      ls_to_wb,

    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_wen,
    output logic [DATA_WIDTH-1:0]     mem_req_addr,
    output logic [1:0]                mem_req_size,
    output logic [DATA_WIDTH-1:0]     mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_req_wstrb,

    input  logic                      mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rsp_rdata,
    input  logic                      mem_rsp_err,

    output logic [DATA_WIDTH-1:0]     lsu_result,
    output logic                      lsu_finished,
    output logic                      lsu_stall,
    output logic                      lsu_fault
);

    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t state;

    // Instruction fields kept for the response phase
    logic [DATA_WIDTH-1:0] addr_q;
    logic [2:0]            funct3_q;
    logic                  wen_q;

    // Decode of the incoming instruction, only meaningful in the ex_to_ls cycle
    logic [ADDR_LSB-1:0]   in_offset;
    logic [1:0]            in_size;
    logic                  in_misaligned;
    logic [DATA_WIDTH-1:0] in_wdata;
    logic [STRB_W-1:0]     in_wstrb;

    // Load data path for the response phase
    logic [DATA_WIDTH-1:0] rsp_shifted;
    logic [DATA_WIDTH-1:0] load_value;

    // Decode access size, alignment and lane-aligned store data/strobes
    always_comb begin
        in_offset     = addr[ADDR_LSB-1:0];
        in_size       = 2'd2;
        in_misaligned = 1'b0;
        in_wdata      = wdata;
        in_wstrb      = '1;
        case (funct3[1:0])
            2'b00: begin
                in_size       = 2'd0;
                in_misaligned = 1'b0;
                in_wdata      = {(DATA_WIDTH/8){wdata[7:0]}};
                in_wstrb      = STRB_W'(1) << in_offset;
            end
            2'b01: begin
                in_size       = 2'd1;
                in_misaligned = addr[0];
                in_wdata      = {(DATA_WIDTH/16){wdata[15:0]}};
                in_wstrb      = STRB_W'(3) << in_offset;
            end
            default: begin
                in_size       = 2'd2;
                in_misaligned = |in_offset;
                in_wdata      = wdata;
                in_wstrb      = '1;
            end
        endcase
    end

    // Move the addressed lanes down to bit 0 and sign/zero-extend by width code
    always_comb begin
        rsp_shifted = mem_rsp_rdata >> {addr_q[ADDR_LSB-1:0], 3'b000};
        load_value  = rsp_shifted;
        case (funct3_q)
            3'b000:  load_value = {{(DATA_WIDTH-8){rsp_shifted[7]}}, rsp_shifted[7:0]};
            3'b100:  load_value = {{(DATA_WIDTH-8){1'b0}}, rsp_shifted[7:0]};
            3'b001:  load_value = {{(DATA_WIDTH-16){rsp_shifted[15]}}, rsp_shifted[15:0]};
            3'b101:  load_value = {{(DATA_WIDTH-16){1'b0}}, rsp_shifted[15:0]};
            default: load_value = rsp_shifted;
        endcase
    end

    // Control FSM with all outputs registered; responses outside WAIT are dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            addr_q        <= '0;
            funct3_q      <= '0;
            wen_q         <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_size  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            lsu_result    <= '0;
            lsu_finished  <= 1'b0;
            lsu_stall     <= 1'b0;
            lsu_fault     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_to_ls) begin
                        addr_q   <= addr;
                        funct3_q <= funct3;
                        wen_q    <= mem_wen;
                        if (!mem_ren && !mem_wen) begin
                            lsu_result   <= exu_result;
                            lsu_finished <= 1'b1;
                            lsu_fault    <= 1'b0;
                            state        <= DONE;
                        end else if (in_misaligned) begin
                            lsu_result   <= addr;
                            lsu_finished <= 1'b1;
                            lsu_fault    <= 1'b1;
                            state        <= DONE;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_req_wen   <= mem_wen;
                            mem_req_addr  <= addr;
                            mem_req_size  <= in_size;
                            mem_req_wdata <= mem_wen ? in_wdata : '0;
                            mem_req_wstrb <= mem_wen ? in_wstrb : '0;
                            lsu_stall     <= 1'b1;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        lsu_stall    <= 1'b0;
                        lsu_finished <= 1'b1;
                        if (mem_rsp_err) begin
                            lsu_fault  <= 1'b1;
                            lsu_result <= addr_q;
                        end else if (wen_q) begin
                            lsu_fault  <= 1'b0;
                            lsu_result <= '0;
                        end else begin
                            lsu_fault  <= 1'b0;
                            lsu_result <= load_value;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (ls_to_wb) begin
                        lsu_finished <= 1'b0;
                        lsu_fault    <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_lsu.sv
// Directed self-checking bench for the load/store unit.
// Inputs change 1ns after the rising edge and outputs are sampled there too,
// so every check sees the state produced by the preceding edge.

module tb_ysyx_23060077_lsu;

    logic        clock;
    logic        reset;
    logic        ex_to_ls;
    logic        mem_ren;
    logic        mem_wen;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exu_result;
    logic        ls_to_wb;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [1:0]  mem_req_size;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        mem_rsp_err;
    logic [31:0] lsu_result;
    logic        lsu_finished;
    logic        lsu_stall;
    logic        lsu_fault;

    int checkCount;
    int failCount;
    int handshakeCount;
    int hsBefore;

    ysyx_23060077_lsu #(
        .DATA_WIDTH (32),
        .ADDR_LSB   (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ex_to_ls      (ex_to_ls),
        .mem_ren       (mem_ren),
        .mem_wen       (mem_wen),
        .funct3        (funct3),
        .addr          (addr),
        .wdata         (wdata),
        .exu_result    (exu_result),
        .ls_to_wb      (ls_to_wb),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_wen   (mem_req_wen),
        .mem_req_addr  (mem_req_addr),
        .mem_req_size  (mem_req_size),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .mem_rsp_err   (mem_rsp_err),
        .lsu_result    (lsu_result),
        .lsu_finished  (lsu_finished),
        .lsu_stall     (lsu_stall),
        .lsu_fault     (lsu_fault)
    );

    // 100 MHz clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count completed request handshakes
    always @(posedge clock) begin
        if (mem_req_valid && mem_req_ready) handshakeCount <= handshakeCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse ex_to_ls for one cycle, then scramble the instruction inputs
    task automatic applyStimulus(input logic ren, input logic wen, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exu);
        mem_ren    = ren;
        mem_wen    = wen;
        funct3     = f3;
        addr       = a;
        wdata      = wd;
        exu_result = exu;
        ex_to_ls   = 1'b1;
        tick();
        ex_to_ls   = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        funct3     = 3'b111;
        addr       = 32'hDEAD_BEE7;
        wdata      = 32'h5555_5555;
        exu_result = 32'h0BAD_F00D;
    endtask

    // Hold ready low for stallCycles, check the request is stable, then handshake and respond
    task automatic serveRequest(input int stallCycles, input logic expWen, input logic [31:0] expAddr,
                                input logic [1:0] expSize, input logic [31:0] expWdata,
                                input logic [3:0] expStrb, input logic [31:0] rdata, input logic err);
        for (int i = 0; i <= stallCycles; i++) begin
            checkOutput("req_valid", {31'd0, mem_req_valid}, 32'd1);
            checkOutput("req_wen", {31'd0, mem_req_wen}, {31'd0, expWen});
            checkOutput("req_addr", mem_req_addr, expAddr);
            checkOutput("req_size", {30'd0, mem_req_size}, {30'd0, expSize});
            checkOutput("req_wstrb", {28'd0, mem_req_wstrb}, {28'd0, expStrb});
            if (expWen) checkOutput("req_wdata", mem_req_wdata, expWdata);
            checkOutput("stall_req", {31'd0, lsu_stall}, 32'd1);
            checkOutput("finished_req", {31'd0, lsu_finished}, 32'd0);
            if (i == stallCycles) mem_req_ready = 1'b1;
            tick();
        end
        mem_req_ready = 1'b0;
        checkOutput("valid_after_hs", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("stall_wait", {31'd0, lsu_stall}, 32'd1);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rdata;
        mem_rsp_err   = err;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        mem_rsp_err   = 1'b0;
    endtask

    // Writeback consumes the result; finished and fault must clear next cycle
    task automatic releaseResult();
        ls_to_wb = 1'b1;
        tick();
        ls_to_wb = 1'b0;
        checkOutput("finished_clear", {31'd0, lsu_finished}, 32'd0);
        checkOutput("fault_clear", {31'd0, lsu_fault}, 32'd0);
    endtask

    task automatic checkFinish(input string tag, input logic [31:0] expResult, input logic expFault);
        checkOutput({tag, "_finished"}, {31'd0, lsu_finished}, 32'd1);
        checkOutput({tag, "_result"}, lsu_result, expResult);
        checkOutput({tag, "_fault"}, {31'd0, lsu_fault}, {31'd0, expFault});
        checkOutput({tag, "_stall"}, {31'd0, lsu_stall}, 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, {31'd0, mem_req_valid}, 32'd0);
        checkOutput({tag, "_wen"}, {31'd0, mem_req_wen}, 32'd0);
        checkOutput({tag, "_addr"}, mem_req_addr, 32'd0);
        checkOutput({tag, "_size"}, {30'd0, mem_req_size}, 32'd0);
        checkOutput({tag, "_wdata"}, mem_req_wdata, 32'd0);
        checkOutput({tag, "_wstrb"}, {28'd0, mem_req_wstrb}, 32'd0);
        checkOutput({tag, "_result"}, lsu_result, 32'd0);
        checkOutput({tag, "_finished"}, {31'd0, lsu_finished}, 32'd0);
        checkOutput({tag, "_stall"}, {31'd0, lsu_stall}, 32'd0);
        checkOutput({tag, "_fault"}, {31'd0, lsu_fault}, 32'd0);
    endtask

    initial begin
        checkCount     = 0;
        failCount      = 0;
        handshakeCount = 0;
        reset          = 1'b1;
        ex_to_ls       = 1'b0;
        mem_ren        = 1'b0;
        mem_wen        = 1'b0;
        funct3         = 3'b000;
        addr           = 32'h0;
        wdata          = 32'h0;
        exu_result     = 32'h0;
        ls_to_wb       = 1'b0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_rdata  = 32'h0;
        mem_rsp_err    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checkAllZero("reset");

        // ALU passthrough
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h8000_0000, 32'h0, 32'h1234_5678);
        checkFinish("alu", 32'h1234_5678, 1'b0);
        checkOutput("alu_no_req", {31'd0, mem_req_valid}, 32'd0);
        releaseResult();

        // lb sign extension, top byte lane, ready immediately
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h0);
        serveRequest(0, 1'b0, 32'h8000_0003, 2'd0, 32'h0, 4'b0000, 32'h80AA_BBCC, 1'b0);
        checkFinish("lb", 32'hFFFF_FF80, 1'b0);
        releaseResult();

        // lhu from upper half
        applyStimulus(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h0);
        serveRequest(0, 1'b0, 32'h8000_0002, 2'd1, 32'h0, 4'b0000, 32'hBEEF_1234, 1'b0);
        checkFinish("lhu", 32'h0000_BEEF, 1'b0);
        releaseResult();

        // lh sign extension from lower half
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'h0, 32'h0);
        serveRequest(1, 1'b0, 32'h8000_0000, 2'd1, 32'h0, 4'b0000, 32'h1234_8001, 1'b0);
        checkFinish("lh", 32'hFFFF_8001, 1'b0);
        releaseResult();

        // lbu from lane 1
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h8000_0001, 32'h0, 32'h0);
        serveRequest(0, 1'b0, 32'h8000_0001, 2'd0, 32'h0, 4'b0000, 32'h0000_F000, 1'b0);
        checkFinish("lbu", 32'h0000_00F0, 1'b0);
        releaseResult();

        // sh with four cycles of backpressure and a single handshake
        hsBefore = handshakeCount;
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h0);
        serveRequest(4, 1'b1, 32'h8000_0002, 2'd1, 32'hABCD_ABCD, 4'b1100, 32'hFFFF_FFFF, 1'b0);
        checkFinish("sh", 32'h0, 1'b0);
        checkOutput("sh_handshakes", handshakeCount - hsBefore, 32'd1);
        releaseResult();

        // sb to lane 1
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h1234_56EE, 32'h0);
        serveRequest(0, 1'b1, 32'h8000_0001, 2'd0, 32'hEEEE_EEEE, 4'b0010, 32'h0, 1'b0);
        checkFinish("sb", 32'h0, 1'b0);
        releaseResult();

        // sw unchanged data, full strobes
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0);
        serveRequest(2, 1'b1, 32'h8000_0004, 2'd2, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
        checkFinish("sw", 32'h0, 1'b0);
        releaseResult();

        // Misaligned lw: no request, immediate fault with address as result
        hsBefore = handshakeCount;
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'h0);
        checkFinish("mis_lw", 32'h8000_0001, 1'b1);
        checkOutput("mis_lw_no_req", {31'd0, mem_req_valid}, 32'd0);
        releaseResult();

        // Misaligned sh at odd address
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h8000_0003, 32'h1111, 32'h0);
        checkFinish("mis_sh", 32'h8000_0003, 1'b1);
        checkOutput("mis_no_handshake", handshakeCount - hsBefore, 32'd0);
        releaseResult();

        // Bus error on lw: fault with address, load data discarded
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h0);
        serveRequest(0, 1'b0, 32'h8000_0010, 2'd2, 32'h0, 4'b0000, 32'h1234_5678, 1'b1);
        checkFinish("buserr", 32'h8000_0010, 1'b1);
        releaseResult();

        // New instruction pulse colliding with ls_to_wb in DONE is ignored
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_0042);
        checkFinish("collide_first", 32'h0000_0042, 1'b0);
        ls_to_wb = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_0099);
        ls_to_wb = 1'b0;
        checkOutput("collide_exit", {31'd0, lsu_finished}, 32'd0);
        tick();
        checkOutput("collide_ignored", {31'd0, lsu_finished}, 32'd0);

        // Reset while waiting for the response; the late response must be ignored
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'h0);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checkOutput("rst_in_wait", {31'd0, lsu_stall}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkAllZero("rst_wait");
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hCAFE_CAFE;
        tick();
        mem_rsp_valid = 1'b0;
        checkOutput("late_rsp_finished", {31'd0, lsu_finished}, 32'd0);
        tick();
        checkOutput("late_rsp_finished2", {31'd0, lsu_finished}, 32'd0);
        checkOutput("late_rsp_result", lsu_result, 32'd0);

        // Unit still works after the mid-transaction reset
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'hA5A5_5A5A);
        checkFinish("post_rst", 32'hA5A5_5A5A, 1'b0);
        releaseResult();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/ysyx_23060077_lsu.md
Name: ysyx_23060077_lsu

Overview:
Load/store stage directly downstream of the execute stage. Takes the execute result (address from the src1+imm adder, store data from src2) and issues one request per instruction on a simple valid/ready memory port. It aligns write data and strobes, sign- or zero-extends load data, and holds a registered result plus a finished flag for writeback. Non-memory instructions pass the execute result through in one cycle.

Parameters:
DATA_WIDTH, 32, datapath and address width
ADDR_LSB, 2, log2 of bytes per word; sets byte-lane select bits

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
ex_to_ls  input  1  one-cycle pulse; instruction handed over from execute; all instruction inputs are valid this cycle
mem_ren  input  1  instruction is a load
mem_wen  input  1  instruction is a store
funct3  input  3  RV32 width/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu
addr  input  DATA_WIDTH  effective address (execute adder sum)
wdata  input  DATA_WIDTH  store data (src2)
exu_result  input  DATA_WIDTH  execute result, used by non-memory instructions
ls_to_wb  input  1  one-cycle pulse; writeback consumed the result
mem_req_valid  output  1  request valid
mem_req_ready  input  1  memory accepts request
mem_req_wen  output  1  1 = write, 0 = read
mem_req_addr  output  DATA_WIDTH  byte address, passed unmodified
mem_req_size  output  2  0 byte, 1 half, 2 word
mem_req_wdata  output  DATA_WIDTH  lane-aligned store data
mem_req_wstrb  output  4  byte strobes, 0 for reads
mem_rsp_valid  input  1  response valid; always accepted, no ready
mem_rsp_rdata  input  DATA_WIDTH  raw word-lane read data
mem_rsp_err  input  1  bus error, qualified by mem_rsp_valid
lsu_result  output  DATA_WIDTH  registered result to writeback
lsu_finished  output  1  result valid, held until ls_to_wb
lsu_stall  output  1  memory access in flight
lsu_fault  output  1  misaligned address or bus error; valid when lsu_finished=1

Behaviour:
- Reset: state IDLE. All outputs 0: mem_req_valid, lsu_result, lsu_finished, lsu_stall, lsu_fault, and all mem_req_* fields. Reset mid-transaction drops the request and ignores any later response that belongs to it.
- Input capture: on ex_to_ls, register addr, wdata, funct3, mem_ren, mem_wen and exu_result. The block does not read these inputs in any later cycle.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE + ex_to_ls + neither ren nor wen: go to DONE next cycle. lsu_result = exu_result, lsu_finished=1 one cycle after the pulse.
  - IDLE + ex_to_ls + ren or wen + aligned: go to REQ. mem_req_valid=1 from the next cycle.
  - IDLE + ex_to_ls + misaligned: go to DONE with lsu_fault=1 and lsu_result = addr. No request is issued. Half access is misaligned if addr[0]=1; word access is misaligned if addr[1:0]≠0.
  - REQ: hold mem_req_valid and all request fields stable until mem_req_ready=1. Handshake completes in the cycle valid&ready; go to WAIT next cycle. Then mem_req_valid drops to 0.
  - WAIT: on mem_rsp_valid, go to DONE. A response is never expected in the handshake cycle itself, so minimum load/store latency is ex_to_ls + 3 cycles to lsu_finished.
  - DONE: lsu_finished=1 and result/fault held. On ls_to_wb, go to IDLE and clear lsu_finished and lsu_fault in the next cycle.
- lsu_stall=1 in REQ and WAIT, 0 otherwise.
- ex_to_ls outside IDLE is a protocol violation and is ignored. ex_to_ls and ls_to_wb in the same DONE cycle: the DONE→IDLE exit wins and the new pulse is ignored.
- Store alignment: byte offset o = addr[1:0].
  - Byte: wdata[7:0] replicated to all lanes; wstrb = 1<<o.
  - Half: wdata[15:0] replicated to both halves; wstrb = 0011<<o.
  - Word: wdata unchanged; wstrb = 1111.
- Load extraction: shift mem_rsp_rdata right by 8·o. Then:
  - Byte: bits [7:0]; sign-extend for funct3 000, zero-extend for 100.
  - Half: bits [15:0]; sign-extend for 001, zero-extend for 101.
  - Word: full word.
- Store completion: lsu_result = 0 on the store response.
- mem_rsp_err=1 on a response sets lsu_fault=1 and lsu_result = addr. Load data is discarded.
- mem_rsp_valid outside WAIT is ignored.

Test Plan:
- ALU passthrough: ex_to_ls with ren=wen=0, exu_result=0x1234_5678 → lsu_finished=1 next cycle with lsu_result=0x1234_5678, no mem_req_valid. ls_to_wb → finished=0 next cycle.
- lb sign extension: addr=0x8000_0003, funct3=000, rdata=0x80AA_BBCC, ready=1 immediately, response 1 cycle later → lsu_result=0xFFFF_FF80. lsu_finished 3 cycles after ex_to_ls.
- lhu: addr=0x8000_0002, funct3=101, rdata=0xBEEF_1234 → lsu_result=0x0000_BEEF.
- sh with backpressure: addr=0x8000_0002, wdata=0x0000_ABCD, ready held 0 for 4 cycles → valid held and fields stable throughout, wstrb=1100, wdata=0xABCD_ABCD, size=1, wen=1. Single handshake.
- Misaligned lw: addr=0x8000_0001 → no request, lsu_fault=1, lsu_result=0x8000_0001 one cycle after ex_to_ls.
- Bus error and reset: lw with mem_rsp_err=1 → fault=1, result=addr. Separately, assert reset in WAIT → all outputs 0 next cycle, and a late mem_rsp_valid produces no finished.
